// File: rtl/tsp_2opt_sched.sv
`default_nettype none
// ============================================================================
// Module  : tsp_2opt_sched
// Brief   : 2-opt iteration scheduler (LFSR candidate pairs, evaluate, apply)
// Revision: 1.0 - initial release
// ============================================================================
module tsp_2opt_sched #(
  parameter int unsigned N        = 64,
  parameter int unsigned IDXW     = 6,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter logic [31:0] MAX_ITER = 32'd2000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  output logic                   o_cand_valid,
  input  logic                   i_cand_ready,
  output logic [IDXW-1:0]        o_cand_i,
  output logic [IDXW-1:0]        o_cand_j,
  input  logic                   i_res_valid,
  input  logic signed [31:0]     i_res_delta,
  output logic                   o_apply_valid,
  output logic [IDXW-1:0]        o_apply_i,
  output logic [IDXW-1:0]        o_apply_j,
  input  logic                   i_apply_done,
  output logic [31:0]            o_iter_cnt,
  output logic [31:0]            o_accept_cnt,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam logic [IDXW-1:0] c_idx_last = IDXW'(N - 1);
  localparam logic [IDXW-1:0] c_min_span = IDXW'(2);
  localparam logic [15:0]     c_lfsr_mask = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_APPLY = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          r_state;
  logic [15:0]     r_lfsr;
  logic            r_cand_valid;
  logic [IDXW-1:0] r_cand_i;
  logic [IDXW-1:0] r_cand_j;
  logic            r_apply_valid;
  logic [IDXW-1:0] r_apply_i;
  logic [IDXW-1:0] r_apply_j;
  logic [31:0]     r_iter_cnt;
  logic [31:0]     r_accept_cnt;
  logic            r_busy;
  logic            r_done;

  logic [IDXW-1:0] w_a;
  logic [IDXW-1:0] w_b;
  logic [IDXW-1:0] w_i;
  logic [IDXW-1:0] w_j;
  logic            w_reject;
  logic [15:0]     w_lfsr_nxt;
  logic [31:0]     w_iter_inc;
  logic [31:0]     w_accept_inc;

  // Pair (0,N-1) is the whole tour; reversing it does not change length.
  assign w_a          = r_lfsr[IDXW-1:0];
  assign w_b          = r_lfsr[2*IDXW-1:IDXW];
  assign w_i          = (w_a < w_b) ? w_a : w_b;
  assign w_j          = (w_a < w_b) ? w_b : w_a;
  assign w_reject     = ((w_j - w_i) < c_min_span) ||
                        ((w_i == '0) && (w_j == c_idx_last));
  assign w_lfsr_nxt   = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_lfsr_mask : 16'h0000);
  assign w_iter_inc   = (&r_iter_cnt)   ? r_iter_cnt   : r_iter_cnt + 32'd1;
  assign w_accept_inc = (&r_accept_cnt) ? r_accept_cnt : r_accept_cnt + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_lfsr        <= SEED;
      r_cand_valid  <= 1'b0;
      r_cand_i      <= '0;
      r_cand_j      <= '0;
      r_apply_valid <= 1'b0;
      r_apply_i     <= '0;
      r_apply_j     <= '0;
      r_iter_cnt    <= '0;
      r_accept_cnt  <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_iter_cnt   <= '0;
            r_accept_cnt <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_GEN;
          end
        end
        S_GEN: begin
          r_lfsr <= w_lfsr_nxt;
          if (!w_reject) begin
            r_cand_i     <= w_i;
            r_cand_j     <= w_j;
            r_cand_valid <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_cand_ready) begin
            r_cand_valid <= 1'b0;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_res_valid) begin
            r_iter_cnt <= w_iter_inc;
            if (i_res_delta < 0) begin
              r_apply_i     <= r_cand_i;
              r_apply_j     <= r_cand_j;
              r_apply_valid <= 1'b1;
              r_state       <= S_APPLY;
            end else if (w_iter_inc == MAX_ITER) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_GEN;
            end
          end
        end
        S_APPLY: begin
          if (i_apply_done) begin
            r_apply_valid <= 1'b0;
            r_accept_cnt  <= w_accept_inc;
            if (r_iter_cnt == MAX_ITER) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_GEN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cand_valid  = r_cand_valid;
  assign o_cand_i      = r_cand_i;
  assign o_cand_j      = r_cand_j;
  assign o_apply_valid = r_apply_valid;
  assign o_apply_i     = r_apply_i;
  assign o_apply_j     = r_apply_j;
  assign o_iter_cnt    = r_iter_cnt;
  assign o_accept_cnt  = r_accept_cnt;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tsp_2opt_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_tsp_2opt_sched
// Brief   : directed self-checking bench for tsp_2opt_sched (MAX_ITER = 3)
// Revision: 1.0 - initial release
// ============================================================================
module tb_tsp_2opt_sched;

  localparam int unsigned N        = 64;
  localparam int unsigned IDXW     = 6;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam logic [31:0] MAX_ITER = 32'd3;

  logic              clk;
  logic              rst_n;
  logic              i_start;
  logic              o_cand_valid;
  logic              i_cand_ready;
  logic [IDXW-1:0]   o_cand_i;
  logic [IDXW-1:0]   o_cand_j;
  logic              i_res_valid;
  logic signed [31:0] i_res_delta;
  logic              o_apply_valid;
  logic [IDXW-1:0]   o_apply_i;
  logic [IDXW-1:0]   o_apply_j;
  logic              i_apply_done;
  logic [31:0]       o_iter_cnt;
  logic [31:0]       o_accept_cnt;
  logic              o_busy;
  logic              o_done;

  int n_checks = 0;
  int n_errors = 0;
  int n_neg    = 0;
  int n_hs     = 0;
  bit saw_cand  = 1'b0;
  bit saw_apply = 1'b0;
  logic [15:0] m_lfsr;

  tsp_2opt_sched #(
    .N(N), .IDXW(IDXW), .SEED(SEED), .MAX_ITER(MAX_ITER)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .o_cand_valid(o_cand_valid), .i_cand_ready(i_cand_ready),
    .o_cand_i(o_cand_i), .o_cand_j(o_cand_j),
    .i_res_valid(i_res_valid), .i_res_delta(i_res_delta),
    .o_apply_valid(o_apply_valid), .o_apply_i(o_apply_i), .o_apply_j(o_apply_j),
    .i_apply_done(i_apply_done),
    .o_iter_cnt(o_iter_cnt), .o_accept_cnt(o_accept_cnt),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && o_cand_valid && i_cand_ready) n_hs++;
  always @(negedge clk) begin
    if (o_cand_valid)  saw_cand  = 1'b1;
    if (o_apply_valid) saw_apply = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference pair generator: one LFSR step per GEN cycle, rejected pairs included.
  task automatic model_next(output logic [IDXW-1:0] ei, output logic [IDXW-1:0] ej);
    logic [IDXW-1:0] a, b;
    for (int k = 0; k < 10000; k++) begin
      a = m_lfsr[5:0];
      b = m_lfsr[11:6];
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      ei = (a < b) ? a : b;
      ej = (a < b) ? b : a;
      if ((ej - ei) >= 2 && !(ei == 0 && ej == IDXW'(N - 1))) return;
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_cand();
    for (int k = 0; k < 100 && !o_cand_valid; k++) @(negedge clk);
    check("cand_valid_timeout", 32'(o_cand_valid), 32'd1);
  endtask

  task automatic do_eval(input logic signed [31:0] delta);
    logic [IDXW-1:0] ei, ej, ci, cj;
    logic [31:0] it0, ac0;
    model_next(ei, ej);
    wait_cand();
    if (!o_cand_valid) return;
    ci = o_cand_i;
    cj = o_cand_j;
    check("cand_i_model", 32'(ci), 32'(ei));
    check("cand_j_model", 32'(cj), 32'(ej));
    check("pair_legal", 32'((cj > ci) && (cj - ci >= 2) && !(ci == 0 && cj == IDXW'(N - 1))), 32'd1);
    it0 = o_iter_cnt;
    ac0 = o_accept_cnt;
    i_cand_ready = 1'b1;
    @(negedge clk);
    i_cand_ready = 1'b0;
    check("cand_valid_drop", 32'(o_cand_valid), 32'd0);
    i_res_valid = 1'b1;
    i_res_delta = delta;
    @(negedge clk);
    i_res_valid = 1'b0;
    i_res_delta = '0;
    check("iter_inc", o_iter_cnt, it0 + 32'd1);
    if (delta < 0) begin
      n_neg++;
      check("apply_valid_set", 32'(o_apply_valid), 32'd1);
      check("apply_i", 32'(o_apply_i), 32'(ci));
      check("apply_j", 32'(o_apply_j), 32'(cj));
      @(negedge clk);
      check("apply_valid_hold", 32'(o_apply_valid), 32'd1);
      i_apply_done = 1'b1;
      @(negedge clk);
      i_apply_done = 1'b0;
      check("apply_valid_clr", 32'(o_apply_valid), 32'd0);
      check("accept_inc", o_accept_cnt, ac0 + 32'd1);
    end else begin
      check("apply_valid_idle", 32'(o_apply_valid), 32'd0);
      check("accept_same", o_accept_cnt, ac0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IDXW-1:0] hi, hj;
    int hs0, acc_sum;
    rst_n = 1'b0; i_start = 1'b0; i_cand_ready = 1'b0; i_res_valid = 1'b0;
    i_res_delta = '0; i_apply_done = 1'b0;
    m_lfsr = SEED;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Test 1: idle after reset
    saw_cand = 1'b0;
    repeat (20) @(negedge clk);
    check("t1_cand_never", 32'(saw_cand), 32'd0);
    check("t1_busy", 32'(o_busy), 32'd0);
    check("t1_done", 32'(o_done), 32'd0);
    check("t1_apply_valid", 32'(o_apply_valid), 32'd0);
    check("t1_iter", o_iter_cnt, 32'd0);
    check("t1_accept", o_accept_cnt, 32'd0);
    check("t1_cand_ij", 32'({o_cand_i, o_cand_j}), 32'd0);

    // Test 2: negative delta applied, first pairs from seed 0xACE1 are (33,51) then (9,48)
    pulse_start();
    check("t2_busy", 32'(o_busy), 32'd1);
    wait_cand();
    check("t2_first_i", 32'(o_cand_i), 32'd33);
    check("t2_first_j", 32'(o_cand_j), 32'd51);
    do_eval(-32'sd5);
    check("t2_iter", o_iter_cnt, 32'd1);
    check("t2_accept", o_accept_cnt, 32'd1);
    @(negedge clk);
    check("t2_next_offered", 32'(o_cand_valid), 32'd1);
    check("t2_second_i", 32'(o_cand_i), 32'd9);
    check("t2_second_j", 32'(o_cand_j), 32'd48);
    do_eval(32'sd0);
    do_eval(32'sd7);
    check("t2_done", 32'(o_done), 32'd1);
    check("t2_busy_end", 32'(o_busy), 32'd0);

    // Test 3: three non-improving evaluations run to completion
    saw_apply = 1'b0;
    hs0 = n_hs;
    pulse_start();
    check("t3_done_clr", 32'(o_done), 32'd0);
    check("t3_iter_clr", o_iter_cnt, 32'd0);
    check("t3_accept_clr", o_accept_cnt, 32'd0);
    for (int e = 0; e < 3; e++) do_eval(32'sd0);
    repeat (10) @(negedge clk);
    check("t3_handshakes", 32'(n_hs - hs0), 32'd3);
    check("t3_done", 32'(o_done), 32'd1);
    check("t3_busy", 32'(o_busy), 32'd0);
    check("t3_iter", o_iter_cnt, 32'd3);
    check("t3_accept", o_accept_cnt, 32'd0);
    check("t3_apply_never", 32'(saw_apply), 32'd0);
    check("t3_cand_idle", 32'(o_cand_valid), 32'd0);

    // Test 4: backpressure holds the candidate; stray pulses ignored
    pulse_start();
    wait_cand();
    hi = o_cand_i;
    hj = o_cand_j;
    for (int c = 0; c < 10; c++) begin
      i_res_valid  = (c == 3);
      i_res_delta  = (c == 3) ? -32'sd1 : 32'sd0;
      i_apply_done = (c == 6);
      @(negedge clk);
    end
    i_res_valid = 1'b0; i_res_delta = '0; i_apply_done = 1'b0;
    check("t4_cand_valid", 32'(o_cand_valid), 32'd1);
    check("t4_cand_i_hold", 32'(o_cand_i), 32'(hi));
    check("t4_cand_j_hold", 32'(o_cand_j), 32'(hj));
    check("t4_iter", o_iter_cnt, 32'd0);
    check("t4_accept", o_accept_cnt, 32'd0);
    check("t4_apply_valid", 32'(o_apply_valid), 32'd0);
    for (int e = 0; e < 3; e++) do_eval(32'sd1);
    check("t4_done", 32'(o_done), 32'd1);

    // Test 5: 1002 evaluations with random deltas
    n_neg = 0;
    acc_sum = 0;
    for (int r = 0; r < 334; r++) begin
      pulse_start();
      for (int e = 0; e < 3; e++) do_eval(int'($urandom_range(0, 200)) - 100);
      check("t5_done", 32'(o_done), 32'd1);
      acc_sum += int'(o_accept_cnt);
    end
    check("t5_accept_total", 32'(acc_sum), 32'(n_neg));

    // Test 6: asynchronous reset while a reversal is pending
    pulse_start();
    wait_cand();
    i_cand_ready = 1'b1;
    @(negedge clk);
    i_cand_ready = 1'b0;
    i_res_valid = 1'b1;
    i_res_delta = -32'sd3;
    @(negedge clk);
    i_res_valid = 1'b0;
    i_res_delta = '0;
    check("t6_apply_pending", 32'(o_apply_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_apply_valid_rst", 32'(o_apply_valid), 32'd0);
    check("t6_busy_rst", 32'(o_busy), 32'd0);
    check("t6_iter_rst", o_iter_cnt, 32'd0);
    check("t6_apply_ij_rst", 32'({o_apply_i, o_apply_j}), 32'd0);
    check("t6_cand_rst", 32'({o_cand_valid, o_cand_i, o_cand_j}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_lfsr = SEED;
    @(negedge clk);
    pulse_start();
    wait_cand();
    check("t6_first_i", 32'(o_cand_i), 32'd33);
    check("t6_first_j", 32'(o_cand_j), 32'd51);
    do_eval(32'sd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
